// File: rtl/bus_rr_arbiter_pkg.sv
// Shared constants, state type and round-robin search for the internal bus arbiter.
package bus_arb_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   // Returns {found, idx}: first set req bit searching from ptr+1 upward, wrapping to ptr last.
   function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [SEL_W-1:0]   ptr);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] cand;
      res = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = ptr + SEL_W'(i);
         if (!res[SEL_W] && req[cand]) begin
            res = {1'b1, cand};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant and data signals of the shared 16-bit internal bus.
interface bus_rr_arbiter_if
   import bus_arb_pkg::*;
   #(parameter int unsigned DATA_W = 16);

   logic [NUM_REQ-1:0] req;
   logic [DATA_W-1:0]  d0;
   logic [DATA_W-1:0]  d1;
   logic [DATA_W-1:0]  d2;
   logic [DATA_W-1:0]  d3;
   logic [NUM_REQ-1:0] gnt;
   logic [SEL_W-1:0]   sel;
   logic               bus_valid;
   logic [DATA_W-1:0]  bus_q;

   modport master (
      output req, d0, d1, d2, d3,
      input  gnt, sel, bus_valid, bus_q
   );

   modport slave (
      input  req, d0, d1, d2, d3,
      output gnt, sel, bus_valid, bus_q
   );

endinterface

// File: rtl/bus_rr_arbiter_four_to_one.sv
// Four-input data mux steered by the arbiter's registered select.
module four_to_one
   import bus_arb_pkg::*;
   #(parameter int unsigned DATA_W = 16)
   (
      input  logic [SEL_W-1:0]  sel,
      input  logic [DATA_W-1:0] d0,
      input  logic [DATA_W-1:0] d1,
      input  logic [DATA_W-1:0] d2,
      input  logic [DATA_W-1:0] d3,
      output logic [DATA_W-1:0] y
   );

   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner selection for PC/MDR/ALU/MARMUX with a bounded tenure under contention.
module bus_rr_arbiter
   import bus_arb_pkg::*;
   #(
      parameter int unsigned DATA_W   = 16,
      parameter int unsigned MAX_HOLD = 8
   )
   (
      input logic            clk,
      input logic            reset,
      bus_rr_arbiter_if.slave bus
   );

   localparam int unsigned      CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam bit               LIMITED  = (MAX_HOLD != 0);

   arb_state_t         state, state_nx;
   logic [SEL_W-1:0]   ptr, ptr_nx;
   logic [SEL_W-1:0]   sel_q, sel_nx;
   logic [NUM_REQ-1:0] gnt_q, gnt_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;

   logic [SEL_W:0]     pick;
   logic               found;
   logic [SEL_W-1:0]   pidx;
   logic               owner_req;
   logic               others;
   logic               timeout;
   logic               grant_new;
   logic [DATA_W-1:0]  mux_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_IDLE;
         ptr   <= '1;
         sel_q <= '0;
         gnt_q <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         sel_q <= sel_nx;
         gnt_q <= gnt_nx;
         cnt   <= cnt_nx;
      end
   end

   // While granted, ptr equals the owner, so a timeout pick can never re-select the owner.
   always_comb begin
      pick      = rr_pick(bus.req, ptr);
      found     = pick[SEL_W];
      pidx      = pick[SEL_W-1:0];
      owner_req = bus.req[sel_q];
      others    = |(bus.req & ~gnt_q);
      timeout   = LIMITED && (cnt == CNT_LAST) && others;

      state_nx  = state;
      ptr_nx    = ptr;
      sel_nx    = sel_q;
      gnt_nx    = gnt_q;
      cnt_nx    = cnt;
      grant_new = 1'b0;

      case (state)
         ARB_IDLE: begin
            if (found) grant_new = 1'b1;
         end
         ARB_GRANT: begin
            if (!owner_req) begin
               if (found) begin
                  grant_new = 1'b1;
               end else begin
                  state_nx = ARB_IDLE;
                  gnt_nx   = '0;
                  cnt_nx   = '0;
               end
            end else if (timeout) begin
               grant_new = 1'b1;
            end else if (LIMITED && (cnt != CNT_LAST)) begin
               cnt_nx = cnt + 1'b1;
            end
         end
      endcase

      if (grant_new) begin
         state_nx     = ARB_GRANT;
         ptr_nx       = pidx;
         sel_nx       = pidx;
         gnt_nx       = '0;
         gnt_nx[pidx] = 1'b1;
         cnt_nx       = '0;
      end
   end

   four_to_one #(.DATA_W(DATA_W)) u_mux (
      .sel (sel_q),
      .d0  (bus.d0),
      .d1  (bus.d1),
      .d2  (bus.d2),
      .d3  (bus.d3),
      .y   (mux_y)
   );

   always_comb begin
      bus.gnt       = gnt_q;
      bus.sel       = sel_q;
      bus.bus_valid = |gnt_q;
      bus.bus_q     = (|gnt_q) ? mux_y : '0;
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Two arbiters (MAX_HOLD=8 and MAX_HOLD=0) on shared stimulus, checked against a tenure-count model.
module tb_bus_rr_arbiter;
   import bus_arb_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req   = '0;
   logic [15:0] d [4];

   int unsigned checks  = 0;
   int unsigned errors  = 0;
   bit          started = 1'b0;

   int m_owner [2];
   int m_ptr   [2];
   int m_held  [2];
   int m_sel   [2];
   int mh      [2] = '{8, 0};

   always #5 clk = ~clk;

   bus_rr_arbiter_if #(.DATA_W(16)) if8 ();
   bus_rr_arbiter_if #(.DATA_W(16)) if0 ();

   assign if8.req = req;
   assign if8.d0  = d[0];
   assign if8.d1  = d[1];
   assign if8.d2  = d[2];
   assign if8.d3  = d[3];
   assign if0.req = req;
   assign if0.d0  = d[0];
   assign if0.d1  = d[1];
   assign if0.d2  = d[2];
   assign if0.d3  = d[3];

   bus_rr_arbiter #(.DATA_W(16), .MAX_HOLD(8)) u8 (.clk(clk), .reset(reset), .bus(if8));
   bus_rr_arbiter #(.DATA_W(16), .MAX_HOLD(0)) u0 (.clk(clk), .reset(reset), .bus(if0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int pick(input int ptr, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int j;
         j = (ptr + k) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic grant(input int n, input int p);
      m_owner[n] = p;
      m_ptr[n]   = p;
      m_sel[n]   = p;
      m_held[n]  = 1;
   endtask

   task automatic model_edge(input int n);
      logic [3:0] oth;
      if (reset) begin
         m_owner[n] = -1;
         m_ptr[n]   = 3;
         m_sel[n]   = 0;
         m_held[n]  = 0;
      end else if (m_owner[n] < 0) begin
         if (req != 0) grant(n, pick(m_ptr[n], req));
      end else if (!req[m_owner[n]]) begin
         if (req != 0) grant(n, pick(m_ptr[n], req));
         else          m_owner[n] = -1;
      end else begin
         oth = req;
         oth[m_owner[n]] = 1'b0;
         if (mh[n] != 0 && m_held[n] >= mh[n] && oth != 0) grant(n, pick(m_ptr[n], req));
         else m_held[n]++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      started = 1'b1;
      #2;
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int n = 0; n < 2; n++) begin
            logic [3:0]  g;
            logic [1:0]  s;
            logic        v;
            logic [15:0] q;
            string       tag;
            tag = (n == 0) ? "h8" : "h0";
            g   = (n == 0) ? if8.gnt       : if0.gnt;
            s   = (n == 0) ? if8.sel       : if0.sel;
            v   = (n == 0) ? if8.bus_valid : if0.bus_valid;
            q   = (n == 0) ? if8.bus_q     : if0.bus_q;
            chk({tag, ".gnt"},   32'(g), (m_owner[n] < 0) ? 32'd0 : (32'd1 << m_owner[n]));
            chk({tag, ".sel"},   32'(s), 32'(m_sel[n]));
            chk({tag, ".valid"}, 32'(v), (m_owner[n] < 0) ? 32'd0 : 32'd1);
            chk({tag, ".bus_q"}, 32'(q), (m_owner[n] < 0) ? 32'd0 : 32'(d[m_owner[n]]));
         end
      end
   end

   initial begin
      for (int k = 0; k < 4; k++) d[k] = 16'h1111 * 16'(k + 1);
      for (int n = 0; n < 2; n++) begin
         m_owner[n] = -1; m_ptr[n] = 3; m_sel[n] = 0; m_held[n] = 0;
      end

      reset = 1'b1; req = 4'b0000;
      repeat (5) begin
         step();
         chk("t1 gnt", 32'(if8.gnt), 32'h0);
         chk("t1 valid", 32'(if8.bus_valid), 32'h0);
         chk("t1 bus_q", 32'(if8.bus_q), 32'h0);
      end

      reset = 1'b0; req = 4'b0001; d[0] = 16'hABCD;
      step();
      chk("t2 gnt", 32'(if8.gnt), 32'h1);
      chk("t2 sel", 32'(if8.sel), 32'h0);
      chk("t2 bus_q", 32'(if8.bus_q), 32'hABCD);
      repeat (4) begin
         step();
         chk("t2 hold", 32'(if8.gnt), 32'h1);
      end
      req = 4'b0000;
      step();
      chk("t2 drop", 32'(if8.gnt), 32'h0);
      chk("t2 drop valid", 32'(if8.bus_valid), 32'h0);

      reset = 1'b1; step();
      reset = 1'b0; req = 4'b1111;
      for (int i = 1; i <= 33; i++) begin
         step();
         chk("t3 gnt", 32'(if8.gnt), 32'(4'b0001 << (((i - 1) / 8) % 4)));
         chk("t3 valid", 32'(if8.bus_valid), 32'h1);
         chk("t3 unlimited", 32'(if0.gnt), 32'h1);
      end

      reset = 1'b1; req = 4'b0000; step();
      reset = 1'b0; req = 4'b0100;
      step();
      chk("t4 gnt2", 32'(if8.gnt), 32'h4);
      req = 4'b1100;
      repeat (3) begin
         step();
         chk("t4 keep2", 32'(if8.gnt), 32'h4);
      end
      req = 4'b1000;
      step();
      chk("t4 gnt3", 32'(if8.gnt), 32'h8);
      chk("t4 valid", 32'(if8.bus_valid), 32'h1);
      chk("t4 sel", 32'(if8.sel), 32'h3);

      reset = 1'b1; req = 4'b0000; step();
      reset = 1'b0; req = 4'b0011;
      repeat (50) begin
         step();
         chk("t5 hold0", 32'(if0.gnt), 32'h1);
      end
      req = 4'b0010;
      step();
      chk("t5 handoff", 32'(if0.gnt), 32'h2);

      reset = 1'b1; req = 4'b0000; step();
      reset = 1'b0; req = 4'b0110;
      step();
      chk("t6 gnt1", 32'(if8.gnt), 32'h2);
      step();
      reset = 1'b1;
      step();
      chk("t6 rst gnt", 32'(if8.gnt), 32'h0);
      chk("t6 rst valid", 32'(if8.bus_valid), 32'h0);
      chk("t6 rst sel", 32'(if8.sel), 32'h0);
      reset = 1'b0;
      step();
      chk("t6 regrant", 32'(if8.gnt), 32'h2);

      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(3) == 0) req[b] = ~req[b];
         end
         for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
         reset = ($urandom_range(199) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
